amstrad_mem_sched: RTL and testbench
====================================

# amstrad_mem_sched

Memory-slot scheduler for the CPC video/CPU shared RAM port. It derives CE_4 and the 2-bit phase from CE_16 and issues one 16-bit video fetch per microsecond in phase 0, using the CRTC MA/RA address. The Z80 access is issued in phase 2, and the Z80 is held in wait until its slot completes. It sits between the CRTC, the Z80 bus glue, the gate array (which consumes vram_D, CE_4 and phase) and the single external memory port.

## Interface
Parameters:
- RFSH_DIV, 4: with refresh compiled in, one refresh is issued every RFSH_DIV microsecond cycles.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high
- CE_16  in  1  16 MHz clock-enable pulse, one CLK wide
- CE_4  out  1  pulse on every 4th CE_16 (same CLK as that CE_16)
- phase  out  2  advances by one on every CE_4, wraps 3->0
- crtc_ma  in  14  CRTC memory address
- crtc_ra  in  5  CRTC raster address
- vram_D  out  16  last completed video word
- vid_valid  out  1  one-CLK pulse when vram_D updates
- cpu_req  in  1  level, held by the Z80 glue until cpu_ack
- cpu_we  in  1  write when 1, sampled at slot start
- cpu_addr  in  16  byte address
- cpu_dout  in  8  write data
- cpu_din  out  8  read data, valid at cpu_ack
- cpu_ack  out  1  one-CLK completion pulse
- WAIT_n  out  1  Z80 wait, active low
- mem_req  out  1  level, held until mem_ack
- mem_we  out  1  write strobe qualifier
- mem_addr  out  16  byte address, bit 0 ignored for video
- mem_wdata  out  8  write data
- mem_rdata  in  16  read data, valid with mem_ack
- mem_ack  in  1  one-CLK completion pulse
- mem_rfsh  out  1  refresh request, same handshake as mem_req
- overrun  out  1  sticky: a slot started while the port was busy

## Operation
- Divider: 2-bit count of CE_16. CE_4 = CE_16 & (count==3). phase increments on the same edge.
- Slot start is defined as the edge where CE_4=1 and phase changes. Video slot: phase becomes 0. CPU slot: phase becomes 2. Refresh slot: phase becomes 1.
- Video address: {crtc_ma[13:12], crtc_ra[2:0], crtc_ma[9:0], 1'b0}. It is sampled at the video slot start. At mem_ack: vram_D <= mem_rdata, and vid_valid pulses.
- CPU access: if cpu_req=1 at CPU slot start, the block issues mem_req with cpu_addr, cpu_we and cpu_dout. On a read, cpu_din <= mem_rdata[7:0] if cpu_addr[0]=0, else mem_rdata[15:8]. cpu_ack pulses with mem_ack.
- WAIT_n = 0 whenever cpu_req=1 and no cpu_ack has yet been returned for this request. It is combinational from cpu_req and registered state. WAIT_n = 1 on the cpu_ack CLK.
- FSM states:
  - IDLE: no transaction.
  - VID: video read outstanding.
  - CPU: Z80 access outstanding.
  - RFSH: refresh outstanding.
  - All three busy states return to IDLE on mem_ack.
- Pending flags pv, pc and pr are set at each slot start whose request cannot be issued because the FSM is busy. When this happens, overrun <= 1. From IDLE, pending slots are served in the order pv > pc > pr, on the next CLK.
- A second slot start of the same kind while its pending flag is still set is dropped. overrun stays 1.
- cpu_req deasserted while in CPU state is a protocol error. The access completes, and cpu_ack still pulses.

## Timing
- Reset values:
  - CE_4=0, phase=0, divider=0.
  - vram_D=0, vid_valid=0, cpu_din=0, cpu_ack=0, WAIT_n=1.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_rfsh=0.
  - overrun=0, FSM=IDLE, all pending flags=0.
- RESET mid-transaction: all outputs return to their reset values on the next edge, and a late mem_ack is ignored.
- mem_req rises on the slot-start edge (registered) and falls on the mem_ack edge. Latency from mem_ack to vid_valid or cpu_ack is 0 CLK (same edge).
- mem_ack arriving while idle is ignored.
- A slot is nominally 4 CE_16 periods. The memory must ack within 3 CE_16 periods to avoid overrun.

## Configuration
- AMSTRAD_SCHED_RFSH_EN defined:
  - Every RFSH_DIV-th phase-1 slot start raises mem_rfsh, or sets pr if the FSM is busy.
  - mem_rfsh is cleared by mem_ack, with priority below CPU.
- Not defined: mem_rfsh is tied 0, RFSH state and pr do not exist, and RFSH_DIV is unused.

## Test plan
- Reset, then free-run CE_16 every 4 CLK -> CE_4 every 16 CLK, phase sequence 0,1,2,3,0, WAIT_n=1, mem_req=0.
- crtc_ma=14'h3000, crtc_ra=5'd2, memory acks 2 CLK after mem_req with rdata 16'hA55A -> mem_addr=16'hD000 at phase 0, vram_D=16'hA55A, one vid_valid pulse.
- cpu_req read at cpu_addr=16'h4001, raised in phase 3 -> WAIT_n low until the phase-2 slot, cpu_din=8'hA5, cpu_ack one CLK, WAIT_n high on that CLK.
- CPU write 8'h3C to 16'h8000 -> mem_we=1, mem_wdata=8'h3C, mem_addr=16'h8000 in phase 2 only.
- Memory delays the video ack past the phase-2 start with cpu_req pending -> overrun=1. The CPU access is issued the CLK after the video ack and completes normally.
- With AMSTRAD_SCHED_RFSH_EN and RFSH_DIV=4 -> exactly one mem_rfsh handshake per 4 phase-1 slots. Assert RESET mid-refresh -> mem_rfsh=0 on the next edge.

Source files
------------

// File: rtl/amstrad_mem_sched.sv
// CPC shared-RAM slot scheduler: video fetch in phase 0, Z80 access in phase 2, optional refresh in phase 1.
// Refresh slots are compiled in with AMSTRAD_SCHED_RFSH_EN.
module amstrad_mem_sched #(
   parameter int RFSH_DIV = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        CE_16,
   output logic        CE_4,
   output logic [1:0]  phase,
   input  logic [13:0] crtc_ma,
   input  logic [4:0]  crtc_ra,
   output logic [15:0] vram_D,
   output logic        vid_valid,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_dout,
   output logic [7:0]  cpu_din,
   output logic        cpu_ack,
   output logic        WAIT_n,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack,
   output logic        mem_rfsh,
   output logic        overrun
);

`ifdef AMSTRAD_SCHED_RFSH_EN
   typedef enum logic [1:0] {IDLE, VID, CPU, RFSH} state_t;
`else
   typedef enum logic [1:0] {IDLE, VID, CPU} state_t;
`endif

   state_t      state, state_n;
   logic [1:0]  div;
   logic        pv, pc, pv_n, pc_n;
   logic        v_start, c_start, want_v, want_c;
   logic [15:0] vid_addr, vram_n, addr_n;
   logic [7:0]  din_n, wdata_n;
   logic        vv_n, ack_n, req_n, we_n, ovr_n;
   logic        unused_inputs;

   assign CE_4     = CE_16 & (div == 2'd3);
   assign WAIT_n   = ~cpu_req | cpu_ack;
   assign v_start  = CE_4 & (phase == 2'd3);
   assign c_start  = CE_4 & (phase == 2'd1) & cpu_req;
   assign vid_addr = {crtc_ma[13:12], crtc_ra[2:0], crtc_ma[9:0], 1'b0};
   assign unused_inputs = ^{crtc_ma[11:10], crtc_ra[4:3]};

`ifdef AMSTRAD_SCHED_RFSH_EN
   logic       pr, pr_n, r_start, want_r, rfsh_n;
   logic [7:0] rcnt;

   assign r_start = CE_4 & (phase == 2'd0) & (rcnt == 8'(RFSH_DIV - 1));

   always_ff @(posedge CLK) begin
      if (RESET) begin
         rcnt     <= '0;
         pr       <= 1'b0;
         mem_rfsh <= 1'b0;
      end else begin
         if (CE_4 && phase == 2'd0)
            rcnt <= (rcnt == 8'(RFSH_DIV - 1)) ? '0 : rcnt + 8'd1;
         pr       <= pr_n;
         mem_rfsh <= rfsh_n;
      end
   end
`else
   localparam int unused_rfsh_div = RFSH_DIV;
   assign mem_rfsh = 1'b0;
`endif

   always_comb begin
      state_n = state;
      pv_n    = pv;
      pc_n    = pc;
      req_n   = mem_req;
      we_n    = mem_we;
      addr_n  = mem_addr;
      wdata_n = mem_wdata;
      vram_n  = vram_D;
      din_n   = cpu_din;
      ovr_n   = overrun;
      vv_n    = 1'b0;
      ack_n   = 1'b0;
      want_v  = pv | v_start;
      want_c  = pc | c_start;
`ifdef AMSTRAD_SCHED_RFSH_EN
      pr_n    = pr;
      rfsh_n  = mem_rfsh;
      want_r  = pr | r_start;
`endif
      if (state == IDLE) begin
         // a fresh slot start losing arbitration to a pending slot is deferred like a busy-port start
         if (want_v) begin
            state_n = VID;
            req_n   = 1'b1;
            we_n    = 1'b0;
            addr_n  = vid_addr;
            pv_n    = 1'b0;
            pc_n    = want_c;
            if (c_start) ovr_n = 1'b1;
`ifdef AMSTRAD_SCHED_RFSH_EN
            pr_n = want_r;
            if (r_start) ovr_n = 1'b1;
`endif
         end else if (want_c) begin
            state_n = CPU;
            req_n   = 1'b1;
            we_n    = cpu_we;
            addr_n  = cpu_addr;
            wdata_n = cpu_dout;
            pc_n    = 1'b0;
`ifdef AMSTRAD_SCHED_RFSH_EN
            pr_n = want_r;
            if (r_start) ovr_n = 1'b1;
         end else if (want_r) begin
            state_n = RFSH;
            rfsh_n  = 1'b1;
            pr_n    = 1'b0;
`endif
         end
      end else begin
         if (v_start) begin pv_n = 1'b1; ovr_n = 1'b1; end
         if (c_start) begin pc_n = 1'b1; ovr_n = 1'b1; end
`ifdef AMSTRAD_SCHED_RFSH_EN
         if (r_start) begin pr_n = 1'b1; ovr_n = 1'b1; end
`endif
         if (mem_ack) begin
            state_n = IDLE;
            req_n   = 1'b0;
            we_n    = 1'b0;
`ifdef AMSTRAD_SCHED_RFSH_EN
            rfsh_n  = 1'b0;
`endif
            if (state == VID) begin
               vram_n = mem_rdata;
               vv_n   = 1'b1;
            end
            if (state == CPU) begin
               ack_n = 1'b1;
               if (!mem_we) din_n = mem_addr[0] ? mem_rdata[15:8] : mem_rdata[7:0];
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= IDLE;
         div       <= '0;
         phase     <= '0;
         pv        <= 1'b0;
         pc        <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         vram_D    <= '0;
         vid_valid <= 1'b0;
         cpu_din   <= '0;
         cpu_ack   <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_n;
         div       <= div + {1'b0, CE_16};
         phase     <= phase + {1'b0, CE_4};
         pv        <= pv_n;
         pc        <= pc_n;
         mem_req   <= req_n;
         mem_we    <= we_n;
         mem_addr  <= addr_n;
         mem_wdata <= wdata_n;
         vram_D    <= vram_n;
         vid_valid <= vv_n;
         cpu_din   <= din_n;
         cpu_ack   <= ack_n;
         overrun   <= ovr_n;
      end
   end

endmodule

// File: tb/tb_amstrad_mem_sched.sv
// Directed bench for amstrad_mem_sched: vector table of video/CPU transactions plus overrun, reset and refresh sequences.
module tb_amstrad_mem_sched;

   logic        CLK = 1'b0;
   logic        RESET, CE_16, CE_4;
   logic [1:0]  phase;
   logic [13:0] crtc_ma;
   logic [4:0]  crtc_ra;
   logic [15:0] vram_D;
   logic        vid_valid;
   logic        cpu_req, cpu_we;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_dout, cpu_din;
   logic        cpu_ack, WAIT_n;
   logic        mem_req, mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_ack, mem_rfsh, overrun;

   always #5 CLK = ~CLK;

   amstrad_mem_sched #(.RFSH_DIV(4)) dut (
      .CLK(CLK), .RESET(RESET), .CE_16(CE_16), .CE_4(CE_4), .phase(phase),
      .crtc_ma(crtc_ma), .crtc_ra(crtc_ra), .vram_D(vram_D), .vid_valid(vid_valid),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
      .cpu_din(cpu_din), .cpu_ack(cpu_ack), .WAIT_n(WAIT_n),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_rfsh(mem_rfsh), .overrun(overrun)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // CE_16 every 4 CLK, driven just after the rising edge
   bit ce_run = 1'b0;
   int ce_cnt = 0;
   initial begin
      CE_16 = 1'b0;
      forever begin
         @(posedge CLK);
         #1;
         if (ce_run && ce_cnt == 3) begin
            CE_16 = 1'b1;
            ce_cnt = 0;
         end else begin
            CE_16 = 1'b0;
            if (ce_run) ce_cnt++;
         end
      end
   end

   // memory model: acks ack_delay+1 negedges after seeing a request
   int          ack_delay = 2;
   bit          force_ack = 1'b0;
   logic [15:0] rdata_val = '0;
   int          wcnt = 0;
   initial begin
      mem_ack = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge CLK);
         if (mem_ack) begin
            mem_ack = 1'b0;
         end else if (force_ack) begin
            mem_ack = 1'b1;
            mem_rdata = rdata_val;
            force_ack = 1'b0;
         end else if (!RESET && (mem_req || mem_rfsh)) begin
            if (wcnt >= ack_delay) begin
               mem_ack = 1'b1;
               mem_rdata = rdata_val;
               wcnt = 0;
            end else wcnt++;
         end else wcnt = 0;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      bit          is_cpu;
      bit          we;
      logic [15:0] addr;
      logic [7:0]  dout;
      logic [13:0] ma;
      logic [4:0]  ra;
      logic [15:0] rdata;
      logic [15:0] exp_addr;
      logic [15:0] exp_data;
   } vec_t;

   vec_t vecs[7];

   task automatic do_video(input vec_t v);
      bit   found;
      logic p;
      crtc_ma = v.ma; crtc_ra = v.ra; rdata_val = v.rdata; ack_delay = 2;
      found = 1'b0; p = mem_req;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge CLK);
         if (mem_req && !p && phase == 2'd0) found = 1'b1;
         p = mem_req;
      end
      chk("vid_req_seen", found, 1);
      chk("vid_addr", mem_addr, v.exp_addr);
      chk("vid_we", mem_we, 0);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge CLK);
         if (vid_valid) found = 1'b1;
      end
      chk("vid_valid_seen", found, 1);
      chk("vram_D", vram_D, v.exp_data);
      @(negedge CLK);
      chk("vid_valid_one_clk", vid_valid, 0);
   endtask

   task automatic do_cpu(input vec_t v);
      bit          got_req, got_ack, wait_hi;
      logic        p;
      logic [1:0]  pp;
      logic [15:0] c_addr;
      logic        c_we;
      logic [7:0]  c_wdata;
      got_req = 0; got_ack = 0; wait_hi = 0; c_addr = '0; c_we = 0; c_wdata = '0;
      pp = phase;
      for (int i = 0; i < 100; i++) begin
         @(negedge CLK);
         if (phase == 2'd3 && pp != 2'd3) break;
         pp = phase;
      end
      rdata_val = v.rdata; ack_delay = 2;
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_dout = v.dout;
      @(negedge CLK);
      chk("cpu_wait_low", WAIT_n, 0);
      p = mem_req;
      for (int i = 0; i < 100 && !got_ack; i++) begin
         @(negedge CLK);
         if (cpu_ack) got_ack = 1'b1;
         else if (WAIT_n) wait_hi = 1'b1;
         if (mem_req && !p && phase == 2'd2) begin
            got_req = 1'b1; c_addr = mem_addr; c_we = mem_we; c_wdata = mem_wdata;
         end
         p = mem_req;
      end
      chk("cpu_ack_seen", got_ack, 1);
      chk("cpu_wait_high_at_ack", WAIT_n, 1);
      chk("cpu_wait_held", wait_hi, 0);
      chk("cpu_req_phase2", got_req, 1);
      chk("cpu_addr", c_addr, v.exp_addr);
      chk("cpu_we", c_we, v.we);
      if (v.we) chk("cpu_wdata", c_wdata, v.exp_data);
      else      chk("cpu_din", cpu_din, v.exp_data);
      cpu_req = 1'b0; cpu_we = 1'b0;
      @(negedge CLK);
      chk("cpu_ack_one_clk", cpu_ack, 0);
      chk("cpu_we_dropped", mem_we, 0);
   endtask

   initial begin
      bit          found;
      int          n, rises;
      logic        p;
      logic [1:0]  pp;

      //        cpu we addr      dout   ma        ra     rdata     exp_addr  exp_data
      vecs[0] = '{0, 0, 16'h0000, 8'h00, 14'h3000, 5'd2,  16'hA55A, 16'hD000, 16'hA55A};
      vecs[1] = '{0, 0, 16'h0000, 8'h00, 14'h03FF, 5'd7,  16'h1234, 16'h3FFE, 16'h1234};
      vecs[2] = '{0, 0, 16'h0000, 8'h00, 14'h1C01, 5'h1D, 16'hBEEF, 16'h6802, 16'hBEEF};
      vecs[3] = '{1, 0, 16'h4001, 8'h00, 14'h1C01, 5'h1D, 16'hA55A, 16'h4001, 16'h00A5};
      vecs[4] = '{1, 0, 16'h4000, 8'h00, 14'h1C01, 5'h1D, 16'hA55A, 16'h4000, 16'h005A};
      vecs[5] = '{1, 1, 16'h8000, 8'h3C, 14'h1C01, 5'h1D, 16'h0000, 16'h8000, 16'h003C};
      vecs[6] = '{1, 0, 16'hFFFF, 8'h00, 14'h1C01, 5'h1D, 16'h7E81, 16'hFFFF, 16'h007E};

      RESET = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_dout = '0;
      crtc_ma = '0; crtc_ra = '0;
      repeat (3) @(negedge CLK);
      chk("rst_CE_4", CE_4, 0);
      chk("rst_phase", phase, 0);
      chk("rst_vram_D", vram_D, 0);
      chk("rst_vid_valid", vid_valid, 0);
      chk("rst_cpu_din", cpu_din, 0);
      chk("rst_cpu_ack", cpu_ack, 0);
      chk("rst_WAIT_n", WAIT_n, 1);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_mem_rfsh", mem_rfsh, 0);
      chk("rst_overrun", overrun, 0);
      RESET = 1'b0; ce_run = 1'b1;

      // stray ack while idle
      rdata_val = 16'hFFFF; force_ack = 1'b1; found = 1'b0;
      repeat (3) begin
         @(negedge CLK);
         if (vid_valid || cpu_ack) found = 1'b1;
      end
      chk("idle_ack_ignored", found, 0);
      chk("idle_ack_vram", vram_D, 0);
      rdata_val = '0;

      for (int k = 0; k < 5; k++) begin
         n = 0;
         do begin
            @(negedge CLK);
            n++;
         end while (!CE_4 && n < 40);
         chk("ce4_seen", CE_4, 1);
         if (k > 0) chk("ce4_period", n, 16);
         chk("phase_seq", phase, k % 4);
         chk("wait_idle", WAIT_n, 1);
         if (k < 4) chk("mem_req_idle", mem_req, 0);
      end

      for (int i = 0; i < 7; i++) begin
         if (vecs[i].is_cpu) do_cpu(vecs[i]);
         else                do_video(vecs[i]);
      end

      // slow video ack overlaps the CPU slot
      chk("no_overrun_yet", overrun, 0);
      ack_delay = 40; found = 1'b0; p = mem_req;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge CLK);
         if (mem_req && !p && phase == 2'd0) found = 1'b1;
         p = mem_req;
      end
      chk("ovr_vid_req", found, 1);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4001; rdata_val = 16'hC33C;
      found = 1'b0;
      for (int i = 0; i < 80 && !found; i++) begin
         @(negedge CLK);
         if (vid_valid) found = 1'b1;
      end
      ack_delay = 2;
      chk("ovr_vid_done", found, 1);
      chk("ovr_vram_D", vram_D, 16'hC33C);
      chk("ovr_set", overrun, 1);
      chk("ovr_req_low_at_ack", mem_req, 0);
      @(negedge CLK);
      chk("ovr_cpu_issued", mem_req, 1);
      chk("ovr_cpu_addr", mem_addr, 16'h4001);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge CLK);
         if (cpu_ack) found = 1'b1;
      end
      chk("ovr_cpu_ack", found, 1);
      chk("ovr_cpu_din", cpu_din, 8'hC3);
      cpu_req = 1'b0;
      @(negedge CLK);
      chk("ovr_sticky", overrun, 1);

      // reset during an outstanding video read, then a late ack
      ack_delay = 30; found = 1'b0; p = mem_req;
      for (int i = 0; i < 100 && !found; i++) begin
         @(negedge CLK);
         if (mem_req && !p && phase == 2'd0) found = 1'b1;
         p = mem_req;
      end
      chk("mid_rst_req", found, 1);
      @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      chk("mid_rst_mem_req", mem_req, 0);
      chk("mid_rst_phase", phase, 0);
      chk("mid_rst_overrun", overrun, 0);
      chk("mid_rst_vram", vram_D, 0);
      chk("mid_rst_addr", mem_addr, 0);
      RESET = 1'b0; ack_delay = 2; force_ack = 1'b1; found = 1'b0;
      repeat (3) begin
         @(negedge CLK);
         if (vid_valid || cpu_ack) found = 1'b1;
      end
      chk("late_ack_ignored", found, 0);
      chk("late_ack_vram", vram_D, 0);

`ifdef AMSTRAD_SCHED_RFSH_EN
      rises = 0; p = mem_rfsh; pp = phase;
      for (int s = 0; s < 8; s++) begin
         for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (mem_rfsh && !p) rises++;
            p = mem_rfsh;
            if (phase == 2'd1 && pp != 2'd1) begin pp = phase; break; end
            pp = phase;
         end
      end
      chk("rfsh_count", rises, 2);
      ack_delay = 20; found = 1'b0; p = mem_rfsh;
      for (int i = 0; i < 400 && !found; i++) begin
         @(negedge CLK);
         if (mem_rfsh && !p) found = 1'b1;
         p = mem_rfsh;
      end
      chk("rfsh_seen", found, 1);
      RESET = 1'b1;
      @(negedge CLK);
      chk("rfsh_mid_rst", mem_rfsh, 0);
      RESET = 1'b0; ack_delay = 2;
      @(negedge CLK);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
